// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit bit length, adding a trailing block when needed.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {S_FILL, S_OUT, S_EXTRA} state_t;

    state_t             state;
    logic [3:0]         w;
    logic [LEN_W-1:0]   len;
    logic               first_pend;
    logic               pend_80;
    logic               pend_len;

    logic [2:0]         b;
    logic [6:0]         p;
    logic [LEN_W-1:0]   len_add;
    logic [31:0]        last_word;
    logic [511:0]       last_blk;
    logic [511:0]       extra_blk;

    assign in_ready = (state == S_FILL);

    // Final block of a message: words already written are kept, the last word is trimmed
    // and marked, everything after it is zeroed and the length lands in words 14..15 if it fits.
    always_comb begin
        b         = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        p         = {1'b0, w, 2'b00} + {4'b0000, b};
        len_add   = len + LEN_W'({b, 3'b000});
        last_word = in_data;
        case (b)
            3'd0:    last_word = 32'h8000_0000;
            3'd1:    last_word = {in_data[31:24], 24'h80_0000};
            3'd2:    last_word = {in_data[31:16], 16'h8000};
            3'd3:    last_word = {in_data[31:8], 8'h80};
            default: last_word = in_data;
        endcase
        last_blk = '0;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) < w)
                last_blk[511-32*i -: 32] = blk_data[511-32*i -: 32];
            else if (4'(i) == w)
                last_blk[511-32*i -: 32] = last_word;
            else if (b == 3'd4 && 4'(i) == w + 4'd1)
                last_blk[511-32*i -: 32] = 32'h8000_0000;
        end
        if (p <= 7'd55)
            last_blk[63:0] = 64'(len_add);
        extra_blk = {(pend_80 ? 32'h8000_0000 : 32'h0000_0000), 416'h0, 64'(len)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FILL;
            w          <= '0;
            len        <= '0;
            first_pend <= 1'b1;
            pend_80    <= 1'b0;
            pend_len   <= 1'b0;
            blk_valid  <= 1'b0;
            blk_data   <= '0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (in_valid) begin
                        if (!in_last) begin
                            blk_data[{~w, 5'b00000} +: 32] <= in_data;
                            len <= len + LEN_W'(32);
                            w   <= w + 4'd1;
                            if (w == 4'd15) begin
                                state     <= S_OUT;
                                blk_valid <= 1'b1;
                                blk_first <= first_pend;
                                blk_last  <= 1'b0;
                            end
                        end else begin
                            blk_data  <= last_blk;
                            len       <= len_add;
                            state     <= S_OUT;
                            blk_valid <= 1'b1;
                            blk_first <= first_pend;
                            blk_last  <= (p <= 7'd55);
                            pend_len  <= (p > 7'd55);
                            pend_80   <= (p == 7'd64);
                        end
                    end
                end
                S_OUT: begin
                    if (blk_ready) begin
                        blk_valid  <= 1'b0;
                        first_pend <= 1'b0;
                        if (pend_len) begin
                            state <= S_EXTRA;
                        end else begin
                            w     <= '0;
                            state <= S_FILL;
                            if (blk_last) begin
                                len        <= '0;
                                first_pend <= 1'b1;
                            end
                        end
                    end
                end
                S_EXTRA: begin
                    // Length-only trailer; the one idle cycle before it separates the two blocks.
                    blk_data  <= extra_blk;
                    blk_valid <= 1'b1;
                    blk_first <= 1'b0;
                    blk_last  <= 1'b1;
                    pend_len  <= 1'b0;
                    pend_80   <= 1'b0;
                    state     <= S_OUT;
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: messages are padded by a byte-level reference model and the
// resulting blocks are compared with what the padder emits under random handshaking.
module tb_sha256_msg_padder;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [2:0]  b;
    } word_t;
    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    int total = 0;
    int bad   = 0;

    word_t word_q[$];
    blk_t  exp_q[$];
    blk_t  got_q[$];
    int    gap_first;
    int    ready_hi;

    localparam logic [511:0] ABC_BLK = {32'h6162_6380, 448'h0, 32'h0000_0018};

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    // Turn a byte message into input words and into the expected padded blocks.
    // last_mode for lengths that are a multiple of 4: 0 random, 1 full last word, 2 extra empty word.
    task automatic add_message(input bq_t msg, input int last_mode);
        int    n;
        int    nfull;
        int    rem;
        bit    full_last;
        bq_t   pad;
        word_t wd;
        blk_t  bk;
        logic [63:0] bits;
        n     = msg.size();
        nfull = n / 4;
        rem   = n % 4;
        full_last = (last_mode == 1) || (last_mode == 0 && $urandom_range(0, 1) == 1);
        if (rem == 0 && n > 0 && full_last) begin
            nfull = nfull - 1;
            rem   = 4;
        end
        for (int i = 0; i < nfull; i++) begin
            wd.d = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
            wd.l = 1'b0;
            wd.b = 3'($urandom_range(0, 7));
            word_q.push_back(wd);
        end
        wd.d = $urandom();
        for (int j = 0; j < rem; j++)
            wd.d[31-8*j -: 8] = msg[4*nfull+j];
        wd.l = 1'b1;
        wd.b = (rem == 4 && $urandom_range(0, 1) == 1) ? 3'($urandom_range(5, 7)) : 3'(rem);
        word_q.push_back(wd);

        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56)
            pad.push_back(8'h00);
        bits = 64'(n) * 64'd8;
        for (int j = 0; j < 8; j++)
            pad.push_back(bits[63-8*j -: 8]);
        for (int k = 0; k < pad.size() / 64; k++) begin
            for (int m = 0; m < 64; m++)
                bk.d[511-8*m -: 8] = pad[64*k+m];
            bk.f = (k == 0);
            bk.l = (k == pad.size() / 64 - 1);
            exp_q.push_back(bk);
        end
    endtask

    task automatic drive_words(input int gap_pct);
        word_t wd;
        int    waited;
        logic  rdy;
        while (word_q.size() > 0) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = $urandom();
                @(negedge clk);
            end
            wd       = word_q.pop_front();
            in_valid = 1'b1;
            in_data  = wd.d;
            in_last  = wd.l;
            in_bytes = wd.b;
            waited   = 0;
            forever begin
                rdy = in_ready;
                @(negedge clk);
                if (rdy) break;
                waited++;
                if (waited > 300) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL input_timeout: in_ready stayed %0b, required 1", in_ready);
                    word_q.delete();
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 5 valid cycles then ready.
    task automatic collect_blocks(input int mode);
        int           cyc;
        int           stall_cnt;
        int           hs;
        bit           prev_stall;
        logic [513:0] prev_out;
        blk_t         e;
        blk_t         g;
        cyc        = 0;
        stall_cnt  = 0;
        hs         = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        gap_first  = 0;
        ready_hi   = 0;
        while (exp_q.size() > 0) begin
            case (mode)
                0:       blk_ready = 1'b1;
                1:       blk_ready = ($urandom_range(0, 2) != 0);
                default: blk_ready = (stall_cnt >= 5);
            endcase
            if (in_ready) ready_hi++;
            if (prev_stall) begin
                total++;
                if ({blk_valid, blk_first, blk_last, blk_data} !== {1'b1, prev_out}) begin
                    bad++;
                    $display("[TB] FAIL hold_stable: got v=%0b %h required v=1 %h", blk_valid, {blk_first, blk_last, blk_data}, prev_out);
                end
            end
            if (blk_valid) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL in_ready_while_out: got %0b required 0", in_ready);
                end
            end
            if (hs == 1 && !blk_valid) gap_first++;
            if (blk_valid && blk_ready) begin
                e = exp_q.pop_front();
                g.d = blk_data;
                g.f = blk_first;
                g.l = blk_last;
                got_q.push_back(g);
                total++;
                if (blk_data !== e.d) begin
                    bad++;
                    $display("[TB] FAIL blk_data #%0d: got %h required %h", hs, blk_data, e.d);
                end
                total++;
                if ({blk_first, blk_last} !== {e.f, e.l}) begin
                    bad++;
                    $display("[TB] FAIL first_last #%0d: got %b required %b", hs, {blk_first, blk_last}, {e.f, e.l});
                end
                hs++;
            end
            prev_stall = blk_valid && !blk_ready;
            prev_out   = {blk_first, blk_last, blk_data};
            if (blk_valid && !blk_ready) stall_cnt++;
            @(negedge clk);
            cyc++;
            if (cyc > 5000) begin
                total++;
                bad++;
                $display("[TB] FAIL block_timeout: %0d blocks missing, required 0", exp_q.size());
                exp_q.delete();
            end
        end
        blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_bytes  = '0;
        blk_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready); end
        total++;
        if (blk_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_blk_valid: got %0b required 0", blk_valid); end
        total++;
        if (blk_data !== 512'h0) begin bad++; $display("[TB] FAIL reset_blk_data: got %h required 0", blk_data); end
        total++;
        if ({blk_first, blk_last} !== 2'b00) begin bad++; $display("[TB] FAIL reset_first_last: got %b required 00", {blk_first, blk_last}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc_and_empty();
        bq_t m;
        got_q.delete();
        m = '{8'h61, 8'h62, 8'h63};
        add_message(m, 0);
        drive_words(0);
        collect_blocks(0);
        m.delete();
        add_message(m, 0);
        drive_words(0);
        collect_blocks(0);
        total++;
        if (got_q.size() != 2 || got_q[0].d !== ABC_BLK) begin
            bad++;
            $display("[TB] FAIL abc_block: got %0d blocks, first %h required %h", got_q.size(), got_q.size() > 0 ? got_q[0].d : 512'h0, ABC_BLK);
        end
        total++;
        if (got_q.size() != 2 || got_q[1].d !== {32'h8000_0000, 480'h0} || !got_q[1].f || !got_q[1].l) begin
            bad++;
            $display("[TB] FAIL empty_block: got %0d blocks, required single 80000000 block with first=last=1", got_q.size());
        end
    endtask

    task automatic test_two_block();
        bq_t   m;
        string s;
        got_q.delete();
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
        add_message(m, 1);
        drive_words(0);
        collect_blocks(0);
        total++;
        if (got_q.size() != 2 || got_q[0].d[63:0] !== 64'h8000_0000_0000_0000 || got_q[0].f !== 1'b1 || got_q[0].l !== 1'b0) begin
            bad++;
            $display("[TB] FAIL two_block_first: got %0d blocks, words14-15 %h required 8000000000000000 first=1 last=0", got_q.size(), got_q.size() > 0 ? got_q[0].d[63:0] : 64'h0);
        end
        total++;
        if (got_q.size() != 2 || got_q[1].d !== {480'h0, 32'h0000_01c0} || got_q[1].l !== 1'b1) begin
            bad++;
            $display("[TB] FAIL two_block_second: got %h required length-only block 1c0 last=1", got_q.size() > 1 ? got_q[1].d : 512'h0);
        end
        total++;
        if (gap_first != 1) begin bad++; $display("[TB] FAIL turnaround_gap: got %0d idle cycles required 1", gap_first); end
        total++;
        if (ready_hi != 0) begin bad++; $display("[TB] FAIL in_ready_between_blocks: got %0d ready cycles required 0", ready_hi); end
    endtask

    task automatic test_full_64();
        bq_t m;
        got_q.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom()));
        add_message(m, 1);
        drive_words(0);
        collect_blocks(1);
        total++;
        if (got_q.size() != 2 || got_q[1].d !== {32'h8000_0000, 448'h0, 32'h0000_0200}) begin
            bad++;
            $display("[TB] FAIL full_64_trailer: got %h required 80000000..00000200", got_q.size() > 1 ? got_q[1].d : 512'h0);
        end
    endtask

    task automatic test_back_to_back();
        bq_t m;
        got_q.delete();
        m = '{8'h61, 8'h62, 8'h63};
        add_message(m, 0);
        add_message(m, 0);
        fork
            drive_words(0);
            collect_blocks(2);
        join
        total++;
        if (got_q.size() != 2 || got_q[1].f !== 1'b1 || got_q[1].d !== ABC_BLK) begin
            bad++;
            $display("[TB] FAIL b2b_second_first: got %0d blocks, first=%0b required 2 blocks with first=1", got_q.size(), got_q.size() > 1 ? got_q[1].f : 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        bq_t   m;
        word_t wd;
        for (int i = 0; i < 7; i++) begin
            wd.d = $urandom();
            wd.l = 1'b0;
            wd.b = 3'd0;
            word_q.push_back(wd);
        end
        drive_words(0);
        rst_n = 1'b0;
        #1;
        total++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_mid_fill: got valid=%0b ready=%0b required 0/1", blk_valid, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_q.delete();
        m = '{8'h61, 8'h62, 8'h63};
        add_message(m, 2);
        drive_words(0);
        collect_blocks(0);
        total++;
        if (got_q.size() != 1 || got_q[0].d !== ABC_BLK || !got_q[0].f || !got_q[0].l) begin
            bad++;
            $display("[TB] FAIL abc_after_reset: got %h required %h", got_q.size() > 0 ? got_q[0].d : 512'h0, ABC_BLK);
        end
        add_message(m, 0);
        drive_words(0);
        exp_q.delete();
        total++;
        if (blk_valid !== 1'b1) begin bad++; $display("[TB] FAIL block_pending: got %0b required 1", blk_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if (blk_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_drops_block: got %0b required 0", blk_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        bq_t m;
        got_q.delete();
        for (int k = 0; k < 14; k++) begin
            m.delete();
            for (int i = 0, n = $urandom_range(0, 150); i < n; i++) m.push_back(8'($urandom()));
            add_message(m, 0);
        end
        fork
            drive_words(30);
            collect_blocks(1);
        join
    endtask

    initial begin
        test_reset();
        test_abc_and_empty();
        test_two_block();
        test_full_64();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
